// File: rtl/rx_frame_sequencer_if.sv
// Serial receive sideband bundle: line/strobe inputs toward the sequencer,
// held-frame data and status flags back to the consumer.
interface rx_frame_sequencer_if #(
  parameter int SIZE = 8
) ();
  logic            BAUD_TICK;
  logic            RXD;
  logic            PARITY_EN;
  logic            PARITY_ODD;
  logic            RD_ACK;
  logic [SIZE-1:0] RX_DATA;
  logic            RXRDY;
  logic            FE;
  logic            PE;
  logic            OE;
  logic            BUSY;
  logic            SHIFT_EN;

  modport master (
    input  BAUD_TICK, RXD, PARITY_EN, PARITY_ODD, RD_ACK,
    output RX_DATA, RXRDY, FE, PE, OE, BUSY, SHIFT_EN
  );

  modport slave (
    output BAUD_TICK, RXD, PARITY_EN, PARITY_ODD, RD_ACK,
    input  RX_DATA, RXRDY, FE, PE, OE, BUSY, SHIFT_EN
  );
endinterface

// File: rtl/rx_frame_sequencer.sv
// Oversampled async-serial frame receiver: start validation, LSB-first data
// shift, optional parity, stop check, and a single held frame with sticky flags.
module rx_frame_sequencer #(
  parameter int SIZE       = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic CLK,
  input  logic RSTN,
  rx_frame_sequencer_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(SIZE + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q;
  logic            sync1_q, sync2_q;
  logic [1:0]      fill_q;
  logic            line_hi_q;
  logic [TW-1:0]   tcnt_q;
  logic [BW-1:0]   bcnt_q;
  logic [SIZE-1:0] shreg_q;
  logic [SIZE-1:0] rx_data_q;
  logic            par_en_q, par_odd_q, perr_q;
  logic            rxrdy_q, fe_q, pe_q, oe_q, shift_en_q;

  logic rxs, fall, bit_hit, done;

  assign rxs = sync2_q;
  // fill_q keeps the reset value of the synchronizer from faking a 1->0 edge
  // when the line is already low as reset is released.
  assign fall    = fill_q[1] & line_hi_q & ~rxs;
  assign bit_hit = bus.BAUD_TICK && (tcnt_q == T_LAST);
  assign done    = (state_q == STOP) && bit_hit;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      fill_q     <= '0;
      line_hi_q  <= 1'b0;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      perr_q     <= 1'b0;
      rxrdy_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      oe_q       <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      sync1_q    <= bus.RXD;
      sync2_q    <= sync1_q;
      fill_q     <= {fill_q[0], 1'b1};
      if (fill_q[1]) line_hi_q <= rxs;
      shift_en_q <= 1'b0;

      // Consumer side: an ack coinciding with completion frees the slot.
      if (done) begin
        if (!rxrdy_q || bus.RD_ACK) begin
          rx_data_q <= shreg_q;
          rxrdy_q   <= 1'b1;
          fe_q      <= ~rxs;
          pe_q      <= perr_q;
          oe_q      <= 1'b0;
        end else begin
          oe_q <= 1'b1;
        end
      end else if (bus.RD_ACK && rxrdy_q) begin
        rxrdy_q <= 1'b0;
        fe_q    <= 1'b0;
        pe_q    <= 1'b0;
        oe_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            tcnt_q  <= '0;
          end
        end
        START: begin
          if (bus.BAUD_TICK) begin
            if (tcnt_q == T_HALF) begin
              if (rxs) begin
                state_q <= IDLE;
              end else begin
                state_q   <= DATA;
                tcnt_q    <= '0;
                bcnt_q    <= '0;
                par_en_q  <= bus.PARITY_EN;
                par_odd_q <= bus.PARITY_ODD;
                perr_q    <= 1'b0;
              end
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        DATA: begin
          if (bit_hit) begin
            tcnt_q     <= '0;
            shreg_q    <= {rxs, shreg_q[SIZE-1:1]};
            shift_en_q <= 1'b1;
            bcnt_q     <= bcnt_q + BW'(1);
            if (bcnt_q == B_LAST) state_q <= par_en_q ? PARITY : STOP;
          end else if (bus.BAUD_TICK) begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        PARITY: begin
          if (bit_hit) begin
            tcnt_q  <= '0;
            perr_q  <= (^shreg_q) ^ rxs ^ par_odd_q;
            state_q <= STOP;
          end else if (bus.BAUD_TICK) begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        STOP: begin
          if (bit_hit) begin
            tcnt_q  <= '0;
            state_q <= IDLE;
          end else if (bus.BAUD_TICK) begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.RX_DATA  = rx_data_q;
  assign bus.RXRDY    = rxrdy_q;
  assign bus.FE       = fe_q;
  assign bus.PE       = pe_q;
  assign bus.OE       = oe_q;
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.SHIFT_EN = shift_en_q;
endmodule
